// File: rtl/cdc_dmux_arb_pkg.sv
// Shared state encoding and width helpers for the CDC DMUX source arbiter.
// Optional ack/timeout path in the top is enabled by CDC_DMUX_ARB_ACK_EN.
package cdc_dmux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int cnt_w(input int h, input int g);
    return clog2(max2(h, g)) + 1;
  endfunction

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_HOLD    = 6;
  localparam int DEF_GAP     = 4;
  localparam int DEF_IDX_W   = idx_w(DEF_NUM_REQ);
  localparam int DEF_CNT_W   = cnt_w(DEF_HOLD, DEF_GAP);

endpackage

// File: rtl/cdc_dmux_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts one past the pointer.
module cdc_dmux_rr_pick
  import cdc_dmux_arb_pkg::*;
#(
  parameter int P_NUM_REQ = 4,
  parameter int P_IDX_W   = 2
) (
  input  logic [P_NUM_REQ-1:0] i_req,
  input  logic [P_IDX_W-1:0]   i_ptr,
  output logic [P_NUM_REQ-1:0] o_gnt,
  output logic [P_IDX_W-1:0]   o_idx,
  output logic                 o_any
);

  logic [P_IDX_W-1:0] w_k;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = '0;
    for (int i = 1; i <= P_NUM_REQ; i++) begin
      w_k = P_IDX_W'((int'(i_ptr) + i) % P_NUM_REQ);
      if (!o_any && i_req[w_k]) begin
        o_any    = 1'b1;
        o_idx    = w_k;
        o_gnt[w_k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_dmux_arbiter.sv
// Round-robin scheduler feeding one CDC DMUX source port with hold/gap pacing.
// Define CDC_DMUX_ARB_ACK_EN to end HOLD early on i_ack_src and flag timeouts.
module cdc_dmux_arbiter
  import cdc_dmux_arb_pkg::*;
#(
  parameter int P_NUM_REQ     = 4,
  parameter int P_DATA_WIDTH  = 16,
  parameter int P_HOLD_CYCLES = 6,
  parameter int P_GAP_CYCLES  = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
`ifdef CDC_DMUX_ARB_ACK_EN
  input  logic                              i_ack_src,
  output logic                              o_timeout,
`endif
  input  logic [P_NUM_REQ-1:0]              i_req_valid,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data,
  output logic [P_NUM_REQ-1:0]              o_req_ready,
  output logic                              o_valid_src,
  output logic [P_DATA_WIDTH-1:0]           o_data_src,
  output logic [idx_w(P_NUM_REQ)-1:0]       o_grant_idx,
  output logic                              o_busy
);

  localparam int IDX_W = idx_w(P_NUM_REQ);
  localparam int CNT_W = cnt_w(P_HOLD_CYCLES, P_GAP_CYCLES);

  arb_state_t              r_state, w_nxt_state;
  logic [CNT_W-1:0]        r_cnt, w_nxt_cnt;
  logic                    r_valid, w_nxt_valid;
  logic [P_DATA_WIDTH-1:0] r_data, w_nxt_data;
  logic [IDX_W-1:0]        r_idx, w_nxt_idx;
  logic [IDX_W-1:0]        r_ptr, w_nxt_ptr;
  logic                    r_timeout, w_nxt_timeout;

  logic [P_NUM_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]        w_win_idx;
  logic                    w_any;
  logic [P_DATA_WIDTH-1:0] w_win_data;
  logic                    w_ack;
  logic                    w_hold_end;

  cdc_dmux_rr_pick #(
    .P_NUM_REQ (P_NUM_REQ),
    .P_IDX_W   (IDX_W)
  ) u_pick (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_win_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_win_data = '0;
    for (int k = 0; k < P_NUM_REQ; k++) begin
      if (w_gnt[k]) w_win_data = i_req_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
    end
  end

`ifdef CDC_DMUX_ARB_ACK_EN
  assign w_ack = i_ack_src;
`else
  assign w_ack = 1'b0;
`endif

  assign w_hold_end = (r_cnt == '0) || w_ack;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_nxt_valid   = r_valid;
    w_nxt_data    = r_data;
    w_nxt_idx     = r_idx;
    w_nxt_ptr     = r_ptr;
    w_nxt_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_nxt_state = HOLD;
          w_nxt_cnt   = CNT_W'(P_HOLD_CYCLES - 1);
          w_nxt_valid = 1'b1;
          w_nxt_data  = w_win_data;
          w_nxt_idx   = w_win_idx;
          w_nxt_ptr   = w_win_idx;
        end
      end
      HOLD: begin
        if (w_hold_end) begin
          w_nxt_state   = GAP;
          w_nxt_cnt     = CNT_W'(P_GAP_CYCLES - 2);
          w_nxt_valid   = 1'b0;
          w_nxt_timeout = !w_ack;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      GAP: begin
        // IDLE itself supplies the last low cycle of the guard gap
        if (r_cnt == '0) w_nxt_state = IDLE;
        else             w_nxt_cnt   = r_cnt - 1'b1;
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_idx     <= '0;
      r_ptr     <= IDX_W'(P_NUM_REQ - 1);
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_valid   <= w_nxt_valid;
      r_data    <= w_nxt_data;
      r_idx     <= w_nxt_idx;
      r_ptr     <= w_nxt_ptr;
      r_timeout <= w_nxt_timeout;
    end
  end

  assign o_req_ready = (r_state == IDLE && !i_rst) ? w_gnt : '0;
  assign o_valid_src = r_valid;
  assign o_data_src  = r_data;
  assign o_grant_idx = r_idx;
  assign o_busy      = (r_state != IDLE);

`ifdef CDC_DMUX_ARB_ACK_EN
  assign o_timeout = r_timeout;
`endif

endmodule

// File: tb/tb_cdc_dmux_arbiter.sv
// Directed and randomized bench for cdc_dmux_arbiter against a timeline model.
// Ack/timeout steps run only when CDC_DMUX_ARB_ACK_EN is defined.
module tb_cdc_dmux_arbiter;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int HOLD = 4;
  localparam int GAP  = 3;
`ifdef CDC_DMUX_ARB_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  req_v;
  logic [W-1:0]  req_d [N];
  logic [N*W-1:0] req_flat;
  logic [N-1:0]  rdy;
  logic          vsrc;
  logic [W-1:0]  dsrc;
  logic [1:0]    gidx;
  logic          busy;
  logic          ack;
  logic          tout;

  always_comb begin
    req_flat = '0;
    for (int k = 0; k < N; k++) req_flat[k*W +: W] = req_d[k];
  end

`ifndef CDC_DMUX_ARB_ACK_EN
  assign tout = 1'b0;
`endif

  cdc_dmux_arbiter #(
    .P_NUM_REQ     (N),
    .P_DATA_WIDTH  (W),
    .P_HOLD_CYCLES (HOLD),
    .P_GAP_CYCLES  (GAP)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
`ifdef CDC_DMUX_ARB_ACK_EN
    .i_ack_src   (ack),
    .o_timeout   (tout),
`endif
    .i_req_valid (req_v),
    .i_req_data  (req_flat),
    .o_req_ready (rdy),
    .o_valid_src (vsrc),
    .o_data_src  (dsrc),
    .o_grant_idx (gidx),
    .o_busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: absolute cycle numbers of the current pulse and next free slot
  int       cyc;
  int       m_ptr, m_free, m_vstart, m_vend, m_to, m_idx;
  logic [W-1:0] m_data;
  logic [N-1:0] sticky;
  bit       rnd_on;
  int       gq[$];
  int       o_vh, o_rp, o_to, low_run, min_gap;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic clr_obs();
    o_vh = 0; o_rp = 0; o_to = 0;
    low_run = -1000; min_gap = 1000;
    gq.delete();
  endtask

  task automatic cycle();
    int w, c;
    logic [N-1:0] er;
    bit ack_hit;
    w = (cyc >= m_free) ? pick(req_v, m_ptr) : -1;
    er = (w >= 0) ? (N'(1) << w) : '0;
    ack_hit = ack && cyc >= m_vstart && cyc <= m_vend;
    @(negedge clk);
    chk("ready", 32'(rdy), 32'(er));
    chk("valid", 32'(vsrc), 32'(cyc >= m_vstart && cyc <= m_vend));
    chk("data", 32'(dsrc), 32'(m_data));
    chk("idx", 32'(gidx), 32'(m_idx));
    chk("busy", 32'(busy), 32'(cyc < m_free));
    chk("timeout", 32'(tout), 32'(ACK_EN && cyc == m_to));
    if (vsrc) o_vh++;
    if (|rdy) o_rp++;
    if (tout) o_to++;
    if (vsrc) begin
      if (low_run > 0 && low_run < min_gap) min_gap = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
    @(posedge clk);
    c = cyc;
    cyc++;
    if (ack_hit) begin
      m_vend = c; m_free = c + GAP; m_to = -1;
    end
    if (w >= 0) begin
      m_vstart = c + 1; m_vend = c + HOLD;
      m_free = c + HOLD + GAP; m_to = c + HOLD + 1;
      m_data = req_d[w]; m_idx = w; m_ptr = w;
      gq.push_back(w);
    end
    #1;
    if (w >= 0) begin
      if (sticky[w]) req_d[w] = W'($urandom);
      else           req_v[w] = 1'b0;
    end
    if (rnd_on) begin
      for (int k = 0; k < N; k++) begin
        if (!req_v[k] && $urandom_range(3) == 0) begin
          req_v[k] = 1'b1; req_d[k] = W'($urandom);
        end else if (req_v[k] && $urandom_range(15) == 0) begin
          req_v[k] = 1'b0;
        end
      end
      if (ACK_EN) ack = ($urandom_range(3) == 0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; ack = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid", 32'(vsrc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(dsrc), 32'd0);
    chk("rst_idx", 32'(gidx), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_timeout", 32'(tout), 32'd0);
    rst = 1'b0;
    cyc++;
    m_ptr = N - 1; m_free = cyc; m_vstart = cyc; m_vend = cyc - 1;
    m_to = -1; m_data = '0; m_idx = 0;
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; req_v = '0; sticky = '0; rnd_on = 1'b0;
    for (int k = 0; k < N; k++) req_d[k] = '0;
    cyc = 0;
    do_reset();

    // single request
    clr_obs();
    req_d[1] = 16'hA5A5; req_v[1] = 1'b1;
    run(12);
    chk("single_rdy", 32'(o_rp), 32'd1);
    chk("single_vh", 32'(o_vh), 32'd4);
    chk("single_n", 32'(gq.size()), 32'd1);
    chk("single_data", 32'(dsrc), 32'hA5A5);
    chk("single_idx", 32'(gidx), 32'd1);

    // all four after reset
    do_reset(); clr_obs();
    for (int k = 0; k < N; k++) begin
      req_d[k] = W'(16'h1000 + k); req_v[k] = 1'b1;
    end
    run(28);
    chk("all_n", 32'(gq.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("all_order", 32'(gq.size() > k ? gq[k] : -1), 32'(k));
    chk("all_vh", 32'(o_vh), 32'd16);
    chk("all_gap", 32'(min_gap), 32'(GAP));

    // continuous req0 and req2
    do_reset(); clr_obs();
    sticky = 4'b0101; req_v = 4'b0101;
    run(28);
    chk("alt_n", 32'(gq.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("alt_order", 32'(gq.size() > k ? gq[k] : -1), 32'((k % 2) * 2));
    chk("alt_gap", 32'(min_gap), 32'(GAP));
    sticky = '0;

    // request arriving during HOLD waits for IDLE
    do_reset(); clr_obs(); req_v = '0;
    req_d[1] = 16'h1111; req_v[1] = 1'b1;
    run(2);
    req_d[3] = 16'h3333; req_v[3] = 1'b1;
    run(14);
    chk("wait_rdy", 32'(o_rp), 32'd2);
    chk("wait_second", 32'(gq.size() > 1 ? gq[1] : -1), 32'd3);
    chk("wait_gap", 32'(min_gap), 32'(GAP));

    // reset in the second HOLD cycle
    do_reset(); clr_obs(); req_v = '0;
    req_d[2] = 16'hBEEF; req_v[2] = 1'b1;
    run(2);
    req_d[0] = 16'h0A0A; req_v[0] = 1'b1;
    req_d[3] = 16'h3A3A; req_v[3] = 1'b1;
    do_reset(); clr_obs();
    run(1);
    chk("rst_first", 32'(gq.size() > 0 ? gq[0] : -1), 32'd0);
    run(8);

`ifdef CDC_DMUX_ARB_ACK_EN
    do_reset(); clr_obs(); req_v = '0;
    req_d[1] = 16'h5151; req_v[1] = 1'b1;
    run(2);
    ack = 1'b1;
    run(1);
    ack = 1'b0;
    run(8);
    chk("ack_vh", 32'(o_vh), 32'd2);
    chk("ack_to", 32'(o_to), 32'd0);
    clr_obs();
    req_d[2] = 16'h5252; req_v[2] = 1'b1;
    run(12);
    chk("noack_vh", 32'(o_vh), 32'd4);
    chk("noack_to", 32'(o_to), 32'd1);
`endif

    // randomized traffic
    do_reset(); clr_obs(); req_v = '0;
    rnd_on = 1'b1;
    run(800);
    rnd_on = 1'b0; ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
